// File: rtl/register_file_mp.sv
// register_file_mp
// Multi-read-port register file with a per-register pending scoreboard.
// DEPTH = 2**ADDR_W words of DATA_W bits. NREAD registered read ports, one
// write per cycle with optional same-cycle write-to-read bypass, and an issue
// port that marks a register as having an in-flight producer.
//
// Ports
//   clock        system clock, all state on posedge
//   resetN       asynchronous active-low reset, clears all state and outputs
//   readAddr     NREAD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   readData     NREAD packed registered read data, port k at [k*DATA_W +: DATA_W]
//   readPending  registered pending flag of the register read on each port
//   regWrite     write enable
//   writeAddr    write address
//   writeData    write data
//   issueValid   marks issueAddr as pending
//   issueAddr    destination register of the issued instruction
//   anyPending   registered OR of the next-state pending vector
module register_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                      clock,
   input  logic                      resetN,
   input  logic [NREAD*ADDR_W-1:0]   readAddr,
   output logic [NREAD*DATA_W-1:0]   readData,
   output logic [NREAD-1:0]          readPending,
   input  logic                      regWrite,
   input  logic [ADDR_W-1:0]         writeAddr,
   input  logic [DATA_W-1:0]         writeData,
   input  logic                      issueValid,
   input  logic [ADDR_W-1:0]         issueAddr,
   output logic                      anyPending
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q  [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;
   logic [DATA_W-1:0] rdata_q [NREAD];
   logic [DATA_W-1:0] rdata_d [NREAD];
   logic [NREAD-1:0]  rpend_q;
   logic [NREAD-1:0]  rpend_d;
   logic              any_q;

   logic wr_en;
   logic iss_en;

   // Register 0 swallows both writes and issues when it is hardwired.
   assign wr_en  = regWrite   && !((ZERO_REG != 0) && (writeAddr == '0));
   assign iss_en = issueValid && !((ZERO_REG != 0) && (issueAddr == '0));

   // Issue is applied after the clear so a new producer wins over the
   // completing one when both target the same register.
   always_comb begin
      pend_d = pend_q;
      if (wr_en) begin
         pend_d[writeAddr] = 1'b0;
      end
      if (iss_en) begin
         pend_d[issueAddr] = 1'b1;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              is_zero;
      logic              hit;

      assign ra      = readAddr[k*ADDR_W +: ADDR_W];
      assign is_zero = (ZERO_REG != 0) && (ra == '0);
      assign hit     = (BYPASS != 0) && wr_en && (ra == writeAddr);

      assign rdata_d[k] = is_zero ? '0
                        : hit     ? writeData
                        :           mem_q[ra];
      // With bypass the read sees the post-update scoreboard.
      assign rpend_d[k] = is_zero ? 1'b0
                        : (BYPASS != 0) ? pend_d[ra]
                        :                 pend_q[ra];

      assign readData[k*DATA_W +: DATA_W] = rdata_q[k];
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         for (int k = 0; k < NREAD; k++) begin
            rdata_q[k] <= '0;
         end
         pend_q  <= '0;
         rpend_q <= '0;
         any_q   <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[writeAddr] <= writeData;
         end
         for (int k = 0; k < NREAD; k++) begin
            rdata_q[k] <= rdata_d[k];
         end
         pend_q  <= pend_d;
         rpend_q <= rpend_d;
         any_q   <= |pend_d;
      end
   end

   assign readPending = rpend_q;
   assign anyPending  = any_q;

endmodule
